// File: rtl/xs_sdr_layer_arbiter.sv
// Round-robin arbiter placing layer-engine graphics-ROM fetches onto the single
// SDRAM read port. One transaction is in flight at a time. Each client holds at
// most one pending request, and a newer address replaces an older one. A
// transaction with no reply is abandoned after TIMEOUT cycles in WAIT.
module xs_sdr_layer_arbiter #(
  parameter int unsigned NCLIENTS = 4,
  parameter int unsigned AW       = 25,
  parameter int unsigned DW       = 16,
  parameter int unsigned TIMEOUT  = 63
) (
  input  logic                   clk,
  input  logic                   RESETn,
  input  logic [NCLIENTS*AW-1:0] cli_addr,
  input  logic [NCLIENTS-1:0]    cli_req,
  output logic [DW-1:0]          cli_data,
  output logic [NCLIENTS-1:0]    cli_rdy,
  output logic [AW-1:0]          mem_addr,
  output logic                   mem_req,
  input  logic                   mem_rdy,
  input  logic [DW-1:0]          mem_data,
  output logic                   err_timeout
);

  localparam int unsigned GW = (NCLIENTS > 1) ? $clog2(NCLIENTS) : 1;
  localparam int unsigned CW = 8;

  typedef enum logic {ST_IDLE, ST_WAIT} state_e;

  state_e                state_q, state_d;
  logic [NCLIENTS-1:0]   pend_q, pend_d;
  logic [NCLIENTS-1:0]   stale_q, stale_d;
  logic [AW-1:0]         pend_addr_q [NCLIENTS];
  logic [AW-1:0]         pend_addr_d [NCLIENTS];
  logic [GW-1:0]         last_grant_q, last_grant_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic [AW-1:0]         mem_addr_q, mem_addr_d;
  logic [NCLIENTS-1:0]   cli_rdy_q, cli_rdy_d;
  logic [DW-1:0]         cli_data_q, cli_data_d;
  logic                  err_q, err_d;

  logic [AW-1:0]         cli_addr_a [NCLIENTS];
  logic                  gnt_found_c;
  logic [GW-1:0]         gnt_idx_c;
  logic [GW-1:0]         rr_idx_c;
  logic [31:0]           rr_j_c;

  // Split the flat client address bus into one entry per client
  always_comb begin
    for (int i = 0; i < int'(NCLIENTS); i++) begin
      cli_addr_a[i] = cli_addr[i*AW +: AW];
    end
  end

  // Round-robin pick: first pending client after last_grant. The scan runs
  // backwards so the nearest candidate is the last one written.
  always_comb begin
    gnt_found_c = 1'b0;
    gnt_idx_c   = '0;
    rr_idx_c    = '0;
    rr_j_c      = '0;
    for (int k = int'(NCLIENTS); k >= 1; k--) begin
      rr_j_c = 32'(last_grant_q) + 32'(k);
      if (rr_j_c >= 32'(NCLIENTS)) begin
        rr_j_c = rr_j_c - 32'(NCLIENTS);
      end
      rr_idx_c = GW'(rr_j_c);
      if (pend_q[rr_idx_c]) begin
        gnt_found_c = 1'b1;
        gnt_idx_c   = rr_idx_c;
      end
    end
  end

  // Next-state: request capture, grant, completion and timeout
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    stale_d      = stale_q;
    pend_addr_d  = pend_addr_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    mem_req_d    = 1'b0;
    mem_addr_d   = mem_addr_q;
    cli_rdy_d    = '0;
    cli_data_d   = cli_data_q;
    err_d        = err_q;

    for (int i = 0; i < int'(NCLIENTS); i++) begin
      if (cli_req[i]) begin
        pend_d[i]      = 1'b1;
        pend_addr_d[i] = cli_addr_a[i];
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (gnt_found_c) begin
          mem_req_d            = 1'b1;
          // A request arriving at the grant edge carries the freshest address
          mem_addr_d           = cli_req[gnt_idx_c] ? cli_addr_a[gnt_idx_c]
                                                    : pend_addr_q[gnt_idx_c];
          pend_d[gnt_idx_c]    = 1'b0;
          stale_d[gnt_idx_c]   = 1'b0;
          last_grant_d         = gnt_idx_c;
          cnt_d                = '0;
          state_d              = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A re-request from the in-flight client supersedes its current fetch
        if (cli_req[last_grant_q]) begin
          stale_d[last_grant_q] = 1'b1;
        end
        if (mem_rdy) begin
          if (!stale_q[last_grant_q]) begin
            cli_rdy_d[last_grant_q] = 1'b1;
            cli_data_d              = mem_data;
          end
          state_d = ST_IDLE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!RESETn) begin
      state_q      <= ST_IDLE;
      pend_q       <= '0;
      stale_q      <= '0;
      last_grant_q <= GW'(NCLIENTS - 1);
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      cli_rdy_q    <= '0;
      cli_data_q   <= '0;
      err_q        <= 1'b0;
      for (int i = 0; i < int'(NCLIENTS); i++) begin
        pend_addr_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      stale_q      <= stale_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      cli_rdy_q    <= cli_rdy_d;
      cli_data_q   <= cli_data_d;
      err_q        <= err_d;
      for (int i = 0; i < int'(NCLIENTS); i++) begin
        pend_addr_q[i] <= pend_addr_d[i];
      end
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign cli_rdy     = cli_rdy_q;
  assign cli_data    = cli_data_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_xs_sdr_layer_arbiter.sv
// Scoreboard bench for xs_sdr_layer_arbiter: directed scenarios push expected
// mem_addr values and client completions; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_xs_sdr_layer_arbiter;

  localparam int unsigned NC = 4;
  localparam int unsigned AW = 25;
  localparam int unsigned DW = 16;

  typedef struct packed {
    logic [NC-1:0] rdy;
    logic [DW-1:0] data;
  } rsp_t;

  logic              clk = 1'b0;
  logic              RESETn;
  logic [NC*AW-1:0]  cli_addr;
  logic [NC-1:0]     cli_req;
  logic [DW-1:0]     cli_data;
  logic [NC-1:0]     cli_rdy;
  logic [AW-1:0]     mem_addr;
  logic              mem_req;
  logic              mem_rdy;
  logic [DW-1:0]     mem_data;
  logic              err_timeout;

  int nvec = 0;
  int nmis = 0;

  logic [AW-1:0] exp_addr_q [$];
  rsp_t          exp_rsp_q  [$];
  logic [AW-1:0] mon_addr;
  rsp_t          mon_rsp;

  xs_sdr_layer_arbiter #(
    .NCLIENTS(NC), .AW(AW), .DW(DW), .TIMEOUT(8)
  ) dut (
    .clk(clk), .RESETn(RESETn),
    .cli_addr(cli_addr), .cli_req(cli_req),
    .cli_data(cli_data), .cli_rdy(cli_rdy),
    .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_rdy(mem_rdy), .mem_data(mem_data),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every mem_req pulse and every cli_rdy pulse must match the scoreboard
  always @(negedge clk) begin
    if (mem_req === 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        nvec++; nmis++;
        $display("FAIL unexpected_mem_req: got addr %0h expected no request", mem_addr);
      end else begin
        mon_addr = exp_addr_q.pop_front();
        check("mem_addr", 64'(mem_addr), 64'(mon_addr));
      end
    end
    if (cli_rdy !== '0) begin
      if (exp_rsp_q.size() == 0) begin
        nvec++; nmis++;
        $display("FAIL unexpected_cli_rdy: got rdy %b data %0h expected none", cli_rdy, cli_data);
      end else begin
        mon_rsp = exp_rsp_q.pop_front();
        check("cli_rdy", 64'(cli_rdy), 64'(mon_rsp.rdy));
        check("cli_data", 64'(cli_data), 64'(mon_rsp.data));
      end
    end
  end

  // One-cycle request pulse from client c; called and returns at a negedge
  task automatic pulse_req(input int c, input logic [AW-1:0] a);
    cli_addr[c*AW +: AW] = a;
    cli_req[c] = 1'b1;
    @(negedge clk);
    cli_req[c] = 1'b0;
  endtask

  task automatic wait_mem_req();
    int n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (mem_req !== 1'b1) begin
      nvec++; nmis++;
      $display("FAIL mem_req_wait: got no mem_req expected one within 20 cycles");
    end
  endtask

  // Controller reply: mem_rdy pulse lat cycles later, then wait for cli_rdy slot
  task automatic reply_after(input int lat, input logic [DW-1:0] d);
    repeat (lat) @(negedge clk);
    mem_rdy  = 1'b1;
    mem_data = d;
    @(negedge clk);
    mem_rdy  = 1'b0;
  endtask

  task automatic serve(input logic [DW-1:0] d);
    wait_mem_req();
    reply_after(2, d);
  endtask

  task automatic do_reset();
    RESETn = 1'b0;
    @(negedge clk);
    RESETn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RESETn   = 1'b0;
    cli_addr = '0;
    cli_req  = '0;
    mem_rdy  = 1'b0;
    mem_data = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_req",  64'(mem_req), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_cli_rdy",  64'(cli_rdy), 64'(0));
    check("rst_cli_data", 64'(cli_data), 64'(0));
    check("rst_err",      64'(err_timeout), 64'(0));
    RESETn = 1'b1;
    @(negedge clk);

    // Single request from client 1
    exp_addr_q.push_back(25'h0123456);
    exp_rsp_q.push_back('{rdy: 4'b0010, data: 16'hBEEF});
    pulse_req(1, 25'h0123456);
    serve(16'hBEEF);
    @(negedge clk);

    // Round robin from reset; client 0 re-requests while client 3 still pending
    do_reset();
    for (int c = 0; c < int'(NC); c++) begin
      cli_addr[c*AW +: AW] = AW'((c + 1) * 16);
      exp_addr_q.push_back(AW'((c + 1) * 16));
    end
    exp_addr_q.push_back(25'h50);
    exp_rsp_q.push_back('{rdy: 4'b0001, data: 16'h1111});
    exp_rsp_q.push_back('{rdy: 4'b0010, data: 16'h2222});
    exp_rsp_q.push_back('{rdy: 4'b0100, data: 16'h3333});
    exp_rsp_q.push_back('{rdy: 4'b1000, data: 16'h4444});
    exp_rsp_q.push_back('{rdy: 4'b0001, data: 16'h5555});
    cli_req = '1;
    @(negedge clk);
    cli_req = '0;
    serve(16'h1111);
    serve(16'h2222);
    wait_mem_req();
    pulse_req(0, 25'h50);
    reply_after(1, 16'h3333);
    serve(16'h4444);
    serve(16'h5555);
    @(negedge clk);

    // Supersede: in-flight client re-requests, first reply is dropped
    do_reset();
    exp_addr_q.push_back(25'h100);
    exp_addr_q.push_back(25'h200);
    exp_rsp_q.push_back('{rdy: 4'b0100, data: 16'hBBBB});
    pulse_req(2, 25'h100);
    wait_mem_req();
    pulse_req(2, 25'h200);
    reply_after(1, 16'hAAAA);
    serve(16'hBBBB);
    @(negedge clk);

    // Latest wins: two requests from client 3 while client 0 is in flight
    do_reset();
    exp_addr_q.push_back(25'h7);
    exp_addr_q.push_back(25'h6);
    exp_rsp_q.push_back('{rdy: 4'b0001, data: 16'h0C0C});
    exp_rsp_q.push_back('{rdy: 4'b1000, data: 16'hD00D});
    pulse_req(0, 25'h7);
    wait_mem_req();
    pulse_req(3, 25'h5);
    pulse_req(3, 25'h6);
    reply_after(1, 16'h0C0C);
    serve(16'hD00D);
    @(negedge clk);

    // Timeout after 8 WAIT cycles; late mem_rdy is ignored; client 1 then served
    do_reset();
    exp_addr_q.push_back(25'h0AB);
    exp_addr_q.push_back(25'h0CD);
    exp_rsp_q.push_back('{rdy: 4'b0010, data: 16'h1234});
    pulse_req(0, 25'h0AB);
    wait_mem_req();
    pulse_req(1, 25'h0CD);
    repeat (6) @(negedge clk);
    check("err_before_timeout", 64'(err_timeout), 64'(0));
    @(negedge clk);
    check("err_at_timeout", 64'(err_timeout), 64'(1));
    mem_rdy  = 1'b1;
    mem_data = 16'hDEAD;
    @(negedge clk);
    mem_rdy  = 1'b0;
    wait_mem_req();
    reply_after(2, 16'h1234);
    check("err_sticky", 64'(err_timeout), 64'(1));
    @(negedge clk);

    // Reset in the middle of WAIT, then a stray mem_rdy
    exp_addr_q.push_back(25'h77);
    pulse_req(1, 25'h77);
    wait_mem_req();
    @(negedge clk);
    do_reset();
    check("rst2_mem_req",  64'(mem_req), 64'(0));
    check("rst2_mem_addr", 64'(mem_addr), 64'(0));
    check("rst2_cli_rdy",  64'(cli_rdy), 64'(0));
    check("rst2_cli_data", 64'(cli_data), 64'(0));
    check("rst2_err",      64'(err_timeout), 64'(0));
    mem_rdy  = 1'b1;
    mem_data = 16'h9999;
    @(negedge clk);
    mem_rdy  = 1'b0;
    repeat (2) @(negedge clk);
    exp_addr_q.push_back(25'h222);
    exp_rsp_q.push_back('{rdy: 4'b0100, data: 16'h2A2A});
    pulse_req(2, 25'h222);
    serve(16'h2A2A);
    check("data_hold", 64'(cli_data), 64'(16'h2A2A));
    repeat (4) @(negedge clk);
    check("data_hold_idle", 64'(cli_data), 64'(16'h2A2A));
    check("addr_queue_drained", 64'(exp_addr_q.size()), 64'(0));
    check("rsp_queue_drained",  64'(exp_rsp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/xs_sdr_layer_arbiter.md
Name: xs_sdr_layer_arbiter

Overview:
- Arbitrates SDRAM graphics-ROM fetches from the video layer engines (BACK1, BACK2, OBJ, CHAR) onto the single SDRAM controller read port.
- Sits directly downstream of each layer's single-request manager.
- Each client side is one address plus a request pulse; it receives a ready pulse with 16-bit data.
- Round-robin grant, one outstanding transaction, latest-address-wins per client, timeout recovery.

Parameters:
- NCLIENTS, 4, number of requesting layer clients (2..8)
- AW, 25, SDRAM word-address width
- DW, 16, data width
- TIMEOUT, 63, max cycles in WAIT before the transaction is abandoned (1..255)

Ports:
- clk  in  1  clk_ram domain clock; all logic posedge.
- RESETn  in  1  synchronous, active-low reset.
- cli_addr  in  NCLIENTS*AW  client i address in bits [i*AW +: AW].
- cli_req  in  NCLIENTS  one-cycle request pulse per client.
- cli_data  out  DW  shared returned data; valid when any cli_rdy bit is 1.
- cli_rdy  out  NCLIENTS  one-cycle completion pulse per client; at most one bit set.
- mem_addr  out  AW  address to the SDRAM controller.
- mem_req  out  1  one-cycle request pulse to the controller.
- mem_rdy  in  1  one-cycle data-valid pulse from the controller.
- mem_data  in  DW  controller read data.
- err_timeout  out  1  sticky flag, set on any timeout.

Behaviour:
- Reset values (RESETn=0 at an edge): all outputs 0; state IDLE; pend, stale and pend_addr cleared; last_grant=NCLIENTS-1, so client 0 has first priority.
- Reset mid-transaction abandons it. A mem_rdy arriving after reset while in IDLE is ignored; no cli_rdy.

Capture:
- cli_req[i]=1 at an edge sets pend[i]=1 and pend_addr[i]=cli_addr[i].
- A repeated request while pending overwrites the address (latest wins). No queue depth beyond 1 per client.

States: IDLE, WAIT.
- IDLE, grant rule:
  - Eligible clients are those with pend[i]=1 before the edge.
  - Select the first eligible client scanning from last_grant+1 modulo NCLIENTS.
  - At the grant edge, register mem_req=1 for exactly one cycle.
  - mem_addr = cli_addr[g] if cli_req[g]=1 at that same edge (bypass), else pend_addr[g].
  - Clear pend[g] and stale[g]; set last_grant=g; clear timeout counter; go to WAIT.
- IDLE with no pending client: stay in IDLE, mem_req=0.
- WAIT, on mem_rdy=1:
  - If stale[g]=0: register cli_data=mem_data and cli_rdy[g]=1 for one cycle.
  - If stale[g]=1: discard the data (superseded); no cli_rdy.
  - Go to IDLE. The next grant occurs no earlier than the edge after the cli_rdy edge. Minimum spacing between mem_req pulses is 2 cycles plus controller latency.
- WAIT, cli_req[g] asserted for the in-flight client: set stale[g]=1 and pend[g]=1, and update the address. The newer request is issued later.
- WAIT, timeout: counter increments each WAIT cycle. When it reaches TIMEOUT without mem_rdy: set err_timeout=1, go to IDLE, no cli_rdy. The client is not re-issued unless it requests again.
- mem_rdy in IDLE (late or spurious) is ignored.
- mem_addr holds its last value between requests. cli_data holds its last value.
- Latency: cli_req edge k → mem_req high in cycle k+2 at the earliest (capture, then grant). mem_rdy edge m → cli_rdy high in cycle m+1.
- Clients other than g are never blocked from capturing; pending requests of non-granted clients persist indefinitely until granted.
- Starvation bound: any pending client is granted within NCLIENTS transactions.

Test Plan:
- Single request: client 1 pulses cli_req with addr 0x0123456; controller replies 3 cycles after mem_req with data 0xBEEF → one mem_req with mem_addr=0x0123456; cli_rdy=4'b0010 for one cycle with cli_data=0xBEEF; other bits 0.
- Round robin: all 4 clients request at the same edge, addresses 0x10/0x20/0x30/0x40 → mem_req order is clients 0,1,2,3. Client 0 then re-requests while client 3 is pending → client 3 is served before client 0.
- Supersede: client 2 requests 0x100; while in WAIT it requests 0x200; controller returns 0xAAAA then 0xBBBB → no cli_rdy for 0xAAAA; second mem_req carries 0x200; cli_rdy[2] with cli_data=0xBBBB.
- Latest wins: client 3 pulses 0x5, then 0x6, while client 0's transaction is in flight → exactly one mem_req for client 3, with mem_addr=0x6.
- Timeout: TIMEOUT=8, grant client 0, withhold mem_rdy → after 8 WAIT cycles err_timeout=1, state IDLE; a pending client 1 is then granted. A late mem_rdy produces no cli_rdy.
- Reset mid-WAIT: assert RESETn=0 for 1 cycle during WAIT, then deliver mem_rdy → no cli_rdy; all outputs 0 after reset; err_timeout cleared; the next request from client 2 (only requester) is granted normally.
